// File: rtl/sum_accumulator.sv
// sum_accumulator: block accumulator behind the 3-operand adder.
// Sums count_p adder results and hands the block total downstream.
module sum_accumulator #(
    parameter  int width_p  = 4,
    parameter  int count_p  = 4,
    localparam int cnt_w_lp = $clog2(count_p + 1),
    localparam int acc_w_lp = width_p + 1 + cnt_w_lp
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [width_p:0]    sum_i,
    input  logic                flush_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [acc_w_lp-1:0] total_o,
    output logic [cnt_w_lp-1:0] count_o
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DONE  = 1'b1;

    localparam logic [cnt_w_lp-1:0] LAST = cnt_w_lp'(count_p - 1);

    logic [0:0]          state_q, state_d;
    logic [acc_w_lp-1:0] acc_q, acc_d;
    logic [acc_w_lp-1:0] total_q, total_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic [acc_w_lp-1:0] acc_sum;

    assign acc_sum = acc_q + acc_w_lp'(sum_i);

    // Next-state: flush wins; ACCUM collects sums, DONE waits for the sink.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (valid_i) begin
                        if (cnt_q == LAST) begin
                            total_d = acc_sum;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            acc_d = acc_sum;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State registers, cleared immediately by the async reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            total_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o = (state_q == ACCUM);
    assign valid_o = (state_q == DONE);
    assign total_o = total_q;
    assign count_o = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: scoreboard bench for sum_accumulator,
// directed scenarios plus randomized traffic, and a count_p=1 instance.
module tb_sum_accumulator;

    localparam int W  = 4;
    localparam int C  = 4;
    localparam int CW = $clog2(C + 1);
    localparam int AW = W + 1 + CW;

    logic clk = 0;
    logic rst_n = 0;
    logic vi = 0, fl = 0, ri = 0;
    logic [W:0] si = '0;
    logic ro, vo;
    logic [AW-1:0] tot;
    logic [CW-1:0] cnt;

    logic v2 = 0, f2 = 0, r2 = 0;
    logic [W:0] s2 = '0;
    logic ro2, vo2;
    logic [W+1:0] tot2;
    logic [0:0] cnt2;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int blk[$];
    bit mdone = 0;
    int mtotal = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.width_p(W), .count_p(C)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .valid_i(vi), .ready_o(ro), .sum_i(si),
        .flush_i(fl), .valid_o(vo), .ready_i(ri),
        .total_o(tot), .count_o(cnt)
    );

    sum_accumulator #(.width_p(W), .count_p(1)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n),
        .valid_i(v2), .ready_o(ro2), .sum_i(s2),
        .flush_i(f2), .valid_o(vo2), .ready_i(r2),
        .total_o(tot2), .count_o(cnt2)
    );

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", n, act, exp);
        end
    endtask

    // Monitor: compare presented total against scoreboard head; pop on handoff.
    always @(negedge clk) begin
        if (rst_n && vo) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%0d required=none", tot);
            end else begin
                chk("total_sb", int'(tot), exp_q[0]);
                if (ri && !fl) void'(exp_q.pop_front());
            end
        end
    end

    task automatic model_clear();
        blk.delete();
        exp_q.delete();
        mdone = 0;
    endtask

    task automatic cyc(input bit v, input int s, input bit f, input bit r);
        bit acc, hand;
        int sum;
        vi = v;
        si = s[W:0];
        fl = f;
        ri = r;
        @(negedge clk);
        acc  = v && !mdone && !f;
        hand = mdone && r && !f;
        @(posedge clk);
        #1;
        if (f) begin
            model_clear();
        end else if (acc) begin
            blk.push_back(s);
            if (blk.size() == C) begin
                sum = 0;
                foreach (blk[k]) sum += blk[k];
                exp_q.push_back(sum);
                mtotal = sum;
                blk.delete();
                mdone = 1;
            end
        end else if (hand) begin
            mdone = 0;
        end
        chk("count", int'(cnt), blk.size());
        chk("valid", int'(vo), int'(mdone));
        chk("ready", int'(ro), int'(!mdone));
        chk("total_hold", int'(tot), mtotal);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 0;
        vi = 0;
        fl = 0;
        ri = 0;
        #1;
        chk("rst_valid", int'(vo), 0);
        chk("rst_count", int'(cnt), 0);
        chk("rst_total", int'(tot), 0);
        model_clear();
        mtotal = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        chk("rst_ready", int'(ro), 1);
    endtask

    initial begin
        #12;
        chk("init_valid", int'(vo), 0);
        chk("init_total", int'(tot), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        chk("init_ready", int'(ro), 1);
        chk("init_count", int'(cnt), 0);

        // 1: back-to-back 1..4
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0);
        chk("t1_total", int'(tot), 10);
        chk("t1_valid", int'(vo), 1);

        // 3: hold in DONE while valid_i pushes 9
        for (int i = 0; i < 5; i++) cyc(1, 9, 0, 0);
        chk("t3_total", int'(tot), 10);
        chk("t3_count", int'(cnt), 0);
        cyc(0, 0, 0, 1);
        chk("t3_ready", int'(ro), 1);

        // 2: 31 x4 with gaps
        for (int i = 0; i < 4; i++) begin
            int g;
            g = $urandom_range(0, 3);
            for (int j = 0; j < g; j++) cyc(0, 0, 0, 0);
            cyc(1, 31, 0, 0);
        end
        chk("t2_total", int'(tot), 124);
        cyc(0, 0, 0, 1);

        // 4: flush discards block and the flush-cycle sum
        cyc(1, 5, 0, 0);
        cyc(1, 6, 0, 0);
        cyc(1, 7, 1, 0);
        chk("t4_count", int'(cnt), 0);
        chk("t4_keep", int'(tot), 124);
        for (int i = 0; i < 4; i++) cyc(1, 5, 0, 0);
        chk("t4_total", int'(tot), 20);
        cyc(0, 0, 0, 1);

        // 5: async reset mid-block
        for (int i = 0; i < 3; i++) cyc(1, 3, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 2, 0, 0);
        chk("t5_total", int'(tot), 8);
        cyc(0, 0, 0, 1);

        // flush while a total is pending
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 0);
        chk("flush_done_valid", int'(vo), 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 31),
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 2) != 0);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        // 6: count_p=1 instance
        @(posedge clk);
        #1;
        v2 = 1;
        s2 = 17;
        @(posedge clk);
        #1;
        v2 = 0;
        chk("c1_valid", int'(vo2), 1);
        chk("c1_total", int'(tot2), 17);
        chk("c1_ready", int'(ro2), 0);
        chk("c1_count", int'(cnt2), 0);
        r2 = 1;
        @(posedge clk);
        #1;
        r2 = 0;
        chk("c1_ready_back", int'(ro2), 1);
        chk("c1_valid_low", int'(vo2), 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
